// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory read arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Counts consecutive arbitrations lost by the debug port and flags when it must win.
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_req,
  input  logic                    f_accept,
  input  logic                    d_accept,
  input  logic [STARVE_CNT_W-1:0] limit,
  output logic                    override_c
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

  logic [STARVE_CNT_W-1:0] cnt;

  // Any edge without a pending debug request breaks the losing streak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (d_accept || !d_req) begin
      cnt <= '0;
    end else if (f_accept && (cnt != CNT_MAX)) begin
      cnt <= cnt + STARVE_CNT_W'(1);
    end
  end

  assign override_c = d_req && (cnt >= limit);

endmodule

// File: rtl/imem_read_arbiter.sv
// Shares one synchronous-read instruction memory between the fetch port (high
// priority) and the debug port (low priority, with anti-starvation override).
module imem_read_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              f_rready,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_rready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  state_t state;
  owner_t owner;

  logic own_rready_c;
  logic handshake_c;
  logic window_c;
  logic override_c;
  logic d_wins_c;
  logic f_accept_c;
  logic d_accept_c;
  logic accept_c;

  // In RESP the owner's rvalid is always high, so its rready alone is the handshake.
  assign own_rready_c = (owner == OWN_F) ? f_rready : d_rready;
  assign handshake_c  = (state == RESP) && own_rready_c;
  assign window_c     = reset && ((state == IDLE) || handshake_c);

  assign d_wins_c = d_req && (override_c || !f_req);
  assign f_gnt    = window_c && f_req && !d_wins_c;
  assign d_gnt    = window_c && d_wins_c;

  assign f_accept_c = f_req && f_gnt;
  assign d_accept_c = d_req && d_gnt;
  assign accept_c   = f_accept_c || d_accept_c;

  imem_arb_starve_ctr u_starve (
    .clk        (clk),
    .reset      (reset),
    .d_req      (d_req),
    .f_accept   (f_accept_c),
    .d_accept   (d_accept_c),
    .limit      (STARVE_CNT_W'(STARVE_LIMIT)),
    .override_c (override_c)
  );

  // Access sequencer: IDLE -> WAIT -> CAPT -> RESP, with RESP chaining straight into WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= OWN_F;
      mem_addr <= '0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      f_rdata  <= '0;
      d_rdata  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: state <= CAPT;
        CAPT: begin
          state <= RESP;
          if (owner == OWN_F) begin
            f_rvalid <= 1'b1;
            f_rdata  <= mem_dout;
          end else begin
            d_rvalid <= 1'b1;
            d_rdata  <= mem_dout;
          end
        end
        RESP: begin
          if (handshake_c) begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (accept_c) begin
              state <= WAIT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (accept_c) begin
        mem_addr <= d_accept_c ? d_addr : f_addr;
        owner    <= d_accept_c ? OWN_D : OWN_F;
      end
    end
  end

endmodule
